reg_desloc_seq: RTL and testbench
=================================

REG_DESLOC_SEQ -- requirements
Module: reg_desloc_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-004 SHALL have port shift_op, input, 3 bits: 000 NOP, 001 LOAD, 010 SLL, 011 SRL, 100 SRA, 101 ROR, 110 ROL; 111 treated as NOP.
REQ-005 SHALL have port shamt, input, 5 bits: shift amount from the shift-control select (0..31; 16 used for LUI).
REQ-006 SHALL have port data_in, input, 32 bits: operand captured on accepted start.
REQ-007 SHALL have port data_out, output, 32 bits: working register contents, always visible.
REQ-008 SHALL have port busy, output, 1 bit: high in SHIFT and DONE.
REQ-009 SHALL have port done, output, 1 bit: single-cycle pulse marking a valid result.

Function
REQ-010 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-011 In IDLE with start=1 and op LOAD/SLL/SRL/SRA/ROR/ROL, SHALL load data_in into the working register and shamt into a 5-bit down-counter.
REQ-012 From IDLE, SHALL go to DONE when op=LOAD or shamt=0, else to SHIFT.
REQ-013 In IDLE with start=1 and op NOP/111, SHALL hold the register and stay in IDLE; done stays 0.
REQ-014 In SHIFT, each cycle SHALL shift the register by exactly one bit and decrement the counter; leaves for DONE on the cycle the counter goes 1->0.
REQ-015 One-bit step rules: SLL fills bit0 with 0; SRL fills bit31 with 0; SRA replicates bit31; ROR moves bit0 to bit31; ROL moves bit31 to bit0.
REQ-016 shift_op and shamt SHALL be latched at accept; changes on the inputs during SHIFT SHALL have no effect.
REQ-017 In DONE, done=1 for exactly one cycle, register held, then IDLE unconditionally.
REQ-018 Latency: done SHALL be high in cycle A+max(shamt,1) where A is the accept cycle's next edge index (shamt=0 or LOAD: one cycle after accept; shamt=N: N cycles after accept).
REQ-019 start asserted while busy=1 SHALL be ignored, neither queued nor altering the operation.
REQ-020 A new start SHALL be accepted the cycle after DONE (in IDLE); back-to-back ops have one idle cycle minimum.
REQ-021 data_out SHALL hold its last value in IDLE indefinitely.

Reset
REQ-022 reset=1 at a clock edge SHALL force IDLE, data_out=32'h0, counter=0, latched op=NOP, busy=0, done=0.
REQ-023 reset SHALL override all activity including mid-SHIFT and DONE; no done pulse follows an aborted operation.
REQ-024 reset and start in the same cycle SHALL leave the block reset, start discarded.

Structure
REQ-025 Op encodings and FSM state encodings SHALL live in shared package shift_pkg.
REQ-026 The one-bit step function SHALL be sub-module shift_step (combinational: 32-bit value, op -> 32-bit value); reg_desloc_seq holds FSM, counter and register.
REQ-027 No combinational path from inputs to data_out, busy or done.

Verification
REQ-028 LUI: data_in=32'h0000ABCD, op=SLL, shamt=16 -> done 16 cycles after accept, data_out=32'hABCD0000.
REQ-029 SRA: data_in=32'h80000010, shamt=4 -> data_out=32'hF8000001 at done (4 cycles); SRL same input -> 32'h08000001.
REQ-030 Zero/load: SLL shamt=0 on 32'h12345678 -> done 1 cycle later, data_out=32'h12345678; LOAD 32'hDEADBEEF shamt=7 -> done 1 cycle later, 32'hDEADBEEF.
REQ-031 Rotate max: ROR shamt=31 on 32'h00000001 -> done after 31 cycles, data_out=32'h00000002; ROL shamt=1 on 32'h80000000 -> 32'h00000001.
REQ-032 Reset mid-op: SRL shamt=20 started, reset at cycle 5 -> next cycle data_out=0, busy=0, no done pulse thereafter.
REQ-033 Busy ignore: during SLL shamt=8, assert start with op=LOAD and new data_in each cycle, toggle shamt -> result unaffected, exactly one done pulse.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared op and FSM state encodings for the sequential one-bit-per-cycle shifter.
package shift_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LOAD = 3'b001,
    OP_SLL  = 3'b010,
    OP_SRL  = 3'b011,
    OP_SRA  = 3'b100,
    OP_ROR  = 3'b101,
    OP_ROL  = 3'b110,
    OP_RSV  = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  function automatic logic op_active(input logic [2:0] op);
    return (op != OP_NOP) && (op != OP_RSV);
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift/rotate step.
module shift_step
  import shift_pkg::*;
(
  input  logic [31:0] val,
  input  logic [2:0]  op,
  output logic [31:0] res
);

  always_comb begin
    res = val;
    case (op_t'(op))
      OP_SLL:  res = {val[30:0], 1'b0};
      OP_SRL:  res = {1'b0, val[31:1]};
      OP_SRA:  res = {val[31], val[31:1]};
      OP_ROR:  res = {val[0], val[31:1]};
      OP_ROL:  res = {val[30:0], val[31]};
      default: res = val;
    endcase
  end

endmodule

// File: rtl/reg_desloc_seq.sv
// Multi-cycle shifter: FSM, down-counter and working register around shift_step.
module reg_desloc_seq
  import shift_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  shift_op,
  input  logic [4:0]  shamt,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        busy,
  output logic        done
);

  state_t      state, nstate;
  logic [31:0] data_q;
  logic [4:0]  cnt;
  op_t         op_q;
  logic [31:0] step_q, step_in;
  logic        accept, direct;

  shift_step u_step  (.val(data_q),  .op(op_q),     .res(step_q));
  shift_step u_first (.val(data_in), .op(shift_op), .res(step_in));

  assign accept = (state == ST_IDLE) && start && op_active(shift_op);
  assign direct = (op_t'(shift_op) == OP_LOAD) || (shamt == 5'd0);

  always_comb begin
    nstate = state;
    case (state)
      ST_IDLE:  if (accept) nstate = (direct || shamt == 5'd1) ? ST_DONE : ST_SHIFT;
      ST_SHIFT: if (cnt == 5'd1) nstate = ST_DONE;
      ST_DONE:  nstate = ST_IDLE;
      default:  nstate = ST_IDLE;
    endcase
  end

  // The first bit step is folded into the accept edge so a shift of N
  // finishes N cycles after accept; SHIFT then runs the remaining N-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      data_q <= 32'h0;
      cnt    <= 5'd0;
      op_q   <= OP_NOP;
    end else begin
      state <= nstate;
      case (state)
        ST_IDLE: if (accept) begin
          op_q <= op_t'(shift_op);
          if (direct) begin
            data_q <= data_in;
            cnt    <= 5'd0;
          end else begin
            data_q <= step_in;
            cnt    <= shamt - 5'd1;
          end
        end
        ST_SHIFT: begin
          data_q <= step_q;
          cnt    <= cnt - 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign data_out = data_q;
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);

endmodule

// File: tb/tb_reg_desloc_seq.sv
// Scoreboard bench: stimulus pushes expected result/cycle, negedge monitor pops on done.
module tb_reg_desloc_seq;

  logic        clk = 0;
  logic        reset, start;
  logic [2:0]  shift_op;
  logic [4:0]  shamt;
  logic [31:0] data_in, data_out;
  logic        busy, done;

  typedef struct { logic [31:0] data; int cyc; string name; } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0, cyc = 0;

  reg_desloc_seq dut (.clk(clk), .reset(reset), .start(start), .shift_op(shift_op),
                      .shamt(shamt), .data_in(data_in), .data_out(data_out),
                      .busy(busy), .done(done));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model(input logic [2:0] op, input int n, input logic [31:0] x);
    if (op == 3'd1 || n == 0) return x;
    case (op)
      3'd2: return x << n;
      3'd3: return x >> n;
      3'd4: return $unsigned($signed(x) >>> n);
      3'd5: return (x >> n) | (x << (32 - n));
      3'd6: return (x << n) | (x >> (32 - n));
      default: return x;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, expected no pending op", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (data_out !== e.data || cyc != e.cyc || busy !== 1'b1) begin
          errors++;
          $display("FAIL %s: data %h cyc %0d busy %b, expected data %h cyc %0d busy 1",
                   e.name, data_out, cyc, busy, e.data, e.cyc);
        end
      end
    end
  end

  task automatic wait_idle(input string nm);
    int t = 0;
    while (busy !== 1'b0 && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) begin
      checks++; errors++;
      $display("FAIL %s_timeout: busy=%b after 100 cycles, expected 0", nm, busy);
    end
  endtask

  // Issues one op from IDLE; called at a negedge, returns at a negedge with start low.
  task automatic issue(input string nm, input logic [2:0] op, input logic [4:0] n,
                       input logic [31:0] d);
    exp_t e;
    wait_idle(nm);
    shift_op = op; shamt = n; data_in = d; start = 1;
    if (op != 3'd0 && op != 3'd7) begin
      e.data = model(op, int'(n), d);
      e.cyc  = cyc + ((op == 3'd1 || n == 0) ? 1 : int'(n));
      e.name = nm;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 0;
  endtask

  task automatic run(input string nm, input logic [2:0] op, input logic [4:0] n,
                     input logic [31:0] d);
    issue(nm, op, n, d);
    wait_idle(nm);
    @(negedge clk);
  endtask

  task automatic drain(input string nm);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_done: %0d pending, expected 0", nm, sb.size());
      sb.delete();
    end
  endtask

  logic [31:0] hold;

  initial begin
    reset = 1; start = 0; shift_op = 0; shamt = 0; data_in = 0;
    repeat (2) @(negedge clk);
    check("reset_data", data_out, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_done", {31'b0, done}, 32'h0);
    reset = 0;
    @(negedge clk);

    run("lui",        3'd2, 5'd16, 32'h0000ABCD);
    check("lui_hold", data_out, 32'hABCD0000);
    run("sra4",       3'd4, 5'd4,  32'h80000010);
    run("srl4",       3'd3, 5'd4,  32'h80000010);
    run("sll0",       3'd2, 5'd0,  32'h12345678);
    run("load",       3'd1, 5'd7,  32'hDEADBEEF);
    run("ror31",      3'd5, 5'd31, 32'h00000001);
    run("rol1",       3'd6, 5'd1,  32'h80000000);
    drain("directed");

    // NOP and reserved op: register held, no done, stays idle.
    hold = data_out;
    run("nop", 3'd0, 5'd3, 32'h11111111);
    check("nop_hold", data_out, hold);
    run("rsv", 3'd7, 5'd9, 32'h22222222);
    check("rsv_hold", data_out, hold);
    check("rsv_busy", {31'b0, busy}, 32'h0);
    repeat (5) @(negedge clk);
    check("idle_hold", data_out, hold);

    // Start while busy must be ignored.
    issue("busy_ign", 3'd2, 5'd8, 32'h0F0F1234);
    while (busy) begin
      start = 1; shift_op = 3'd1; data_in = $urandom; shamt = shamt ^ 5'h1F;
      @(negedge clk);
      if (!busy) start = 0;
    end
    start = 0;
    @(negedge clk);
    drain("busy_ign");

    for (int i = 0; i < 40; i++)
      run("rand", 3'($urandom_range(0, 7)), 5'($urandom), $urandom);
    drain("rand");

    // Reset mid-op: aborted op leaves no done pulse.
    issue("rst_mid", 3'd3, 5'd20, 32'hFFFF0000);
    repeat (4) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    sb.delete();
    check("rst_mid_data", data_out, 32'h0);
    check("rst_mid_busy", {31'b0, busy}, 32'h0);
    repeat (25) @(negedge clk);

    // Reset and start together: start discarded.
    run("pre", 3'd1, 5'd0, 32'hCAFEF00D);
    reset = 1; start = 1; shift_op = 3'd1; data_in = 32'h55555555;
    @(negedge clk);
    reset = 0; start = 0;
    check("rst_start_data", data_out, 32'h0);
    check("rst_start_busy", {31'b0, busy}, 32'h0);
    repeat (3) @(negedge clk);
    check("rst_start_idle", data_out, 32'h0);
    drain("end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
